// File: rtl/dmem_access_unit_pkg.sv
// dmem_access_unit_pkg: shared funct3 encodings, FSM states and store lane replication.
//   lane_rep(f3, a, d) -> {be, wdata} for sb/sh/sw; any other store funct3 maps to sw lanes.
package dmem_access_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
    } lane_t;

    function automatic lane_t lane_rep(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d);
        lane_t r;
        r.be    = (f3 == F3_SB) ? 4'b0001 << a : (f3 == F3_SH) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        r.wdata = (f3 == F3_SB) ? {4{d[7:0]}} : (f3 == F3_SH) ? {2{d[15:0]}} : d;
        return r;
    endfunction

endpackage

// File: rtl/dmem_access_unit_store_align.sv
// dmem_access_unit_store_align: combinational byte-enable, store-lane and alignment check.
//   in : is_load_i, fu3_i, addr_i (byte offset), store_data_i
//   out: be_o, wdata_o (zero for loads), misalign_o
module dmem_access_unit_store_align
    import dmem_access_unit_pkg::*;
(
    input  logic        is_load_i,
    input  logic [2:0]  fu3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] store_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o
);

    logic        ld_legal, st_legal, half, word;
    logic [2:0]  f3n;
    lane_t       lane;

    // Unknown funct3 values are treated as word accesses, so they get the word alignment rule.
    assign ld_legal = fu3_i == F3_LB || fu3_i == F3_LH || fu3_i == F3_LW || fu3_i == F3_LBU || fu3_i == F3_LHU;
    assign st_legal = fu3_i == F3_SB || fu3_i == F3_SH || fu3_i == F3_SW;
    assign f3n      = (is_load_i ? ld_legal : st_legal) ? fu3_i : (is_load_i ? F3_LW : F3_SW);
    assign half     = is_load_i ? (f3n == F3_LH || f3n == F3_LHU) : f3n == F3_SH;
    assign word     = is_load_i ? f3n == F3_LW : f3n == F3_SW;
    assign lane     = lane_rep(f3n, addr_i, store_data_i);

    assign misalign_o = (half && addr_i[0]) || (word && addr_i != 2'b00);
    assign be_o       = is_load_i ? 4'b1111 : lane.be;
    assign wdata_o    = is_load_i ? 32'h0 : lane.wdata;

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: memory-stage load/store controller with req/gnt/rvalid handshake and timeout.
//   pipeline side: mem_read, mem_write, fu3, alu_addr, store_data in; stall out
//   memory side  : dmem_req/we/be/addr/wdata out; dmem_gnt, dmem_rvalid, dmem_rdata in
//   load side    : load_word, load_addr, load_fu3, load_valid out
//   status pulses: store_done, misalign, bus_err
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  fu3,
    input  logic [31:0] alu_addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_word,
    output logic [1:0]  load_addr,
    output logic [2:0]  load_fu3,
    output logic        load_valid,
    output logic        store_done,
    output logic        misalign,
    output logic        bus_err
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d, we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, lword_q, lword_d;
    logic [1:0]        laddr_q, laddr_d;
    logic [2:0]        lfu3_q, lfu3_d;
    logic              lv_q, lv_d, sd_q, sd_d, mis_q, mis_d, berr_q, berr_d;
    logic              acc, sa_mis, timeout, stall_c;
    logic [3:0]        sa_be;
    logic [31:0]       sa_wdata;

    assign acc = mem_read | mem_write;
    // >= rather than == so a grant on the last REQ cycle still times out in WAIT_R.
    assign timeout = cnt_q >= CNT_W'(TIMEOUT - 1);

    dmem_access_unit_store_align u_align (
        .is_load_i    (mem_read),
        .fu3_i        (fu3),
        .addr_i       (alu_addr[1:0]),
        .store_data_i (store_data),
        .be_o         (sa_be),
        .wdata_o      (sa_wdata),
        .misalign_o   (sa_mis)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lword_d = lword_q;
        laddr_d = laddr_q;
        lfu3_d  = lfu3_q;
        lv_d    = 1'b0;
        sd_d    = 1'b0;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            S_IDLE: if (acc) begin
                cnt_d = '0;
                if (sa_mis) begin
                    mis_d = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    we_d    = ~mem_read;
                    be_d    = sa_be;
                    addr_d  = {alu_addr[31:2], 2'b00};
                    wdata_d = sa_wdata;
                    laddr_d = mem_read ? alu_addr[1:0] : laddr_q;
                    lfu3_d  = mem_read ? fu3 : lfu3_q;
                end
            end
            S_REQ: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (dmem_gnt) begin
                    req_d   = 1'b0;
                    state_d = we_q ? S_DONE : S_WAIT_R;
                    sd_d    = we_q;
                end else if (timeout) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                    berr_d  = 1'b1;
                    lword_d = we_q ? lword_q : 32'h0;
                end
            end
            S_WAIT_R: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (dmem_rvalid) begin
                    lword_d = dmem_rdata;
                    lv_d    = 1'b1;
                    state_d = S_DONE;
                end else if (timeout) begin
                    lword_d = 32'h0;
                    berr_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            lword_q <= '0;
            laddr_q <= '0;
            lfu3_q  <= '0;
            lv_q    <= 1'b0;
            sd_q    <= 1'b0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lword_q <= lword_d;
            laddr_q <= laddr_d;
            lfu3_q  <= lfu3_d;
            lv_q    <= lv_d;
            sd_q    <= sd_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    // stall is combinational from the request inputs, so it is masked while reset holds.
    assign stall      = stall_c & ~rst;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_be    = be_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign load_word  = lword_q;
    assign load_addr  = laddr_q;
    assign load_fu3   = lfu3_q;
    assign load_valid = lv_q;
    assign store_done = sd_q;
    assign misalign   = mis_q;
    assign bus_err    = berr_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: scoreboard bench for dmem_access_unit with directed and random traffic.
module tb_dmem_access_unit;

    localparam int TMO = 16;

    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  fu3 = '0;
    logic [31:0] alu_addr = '0, store_data = '0;
    logic        stall, dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, load_word;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [1:0]  load_addr;
    logic [2:0]  load_fu3;
    logic        load_valid, store_done, misalign, bus_err;

    dmem_access_unit #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .fu3(fu3),
        .alu_addr(alu_addr), .store_data(store_data), .stall(stall), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .load_word(load_word), .load_addr(load_addr), .load_fu3(load_fu3),
        .load_valid(load_valid), .store_done(store_done), .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [3:0]  kind;
        logic        chk_load;
        logic [31:0] word;
        logic [1:0]  la;
        logic [2:0]  lf;
    } exp_t;

    typedef struct {
        int          last;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    exp_t        q[$];
    req_t        rq[$];
    int          cyc = 0, errors = 0, checks = 0;
    int          st_lo = 0, st_hi = -1, rq_lo = 0, rq_hi = -1;
    int          gnt_cyc = -1, rv_cyc = -1, spur_cyc = -1;
    logic [31:0] rword = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endfunction

    // Memory responder: replies purely on the schedule chosen by the stimulus.
    always @(posedge clk) begin
        #1;
        dmem_gnt    = cyc == gnt_cyc;
        dmem_rvalid = cyc == rv_cyc || cyc == spur_cyc;
        dmem_rdata  = cyc == rv_cyc ? rword : 32'hBAD0_0000 | 32'(cyc);
    end

    // Monitor: windows for stall/dmem_req, request contents, and response pulses against the queue.
    always @(negedge clk) begin
        logic [3:0] resp;
        exp_t e;
        while (rq.size() > 0 && cyc > rq[0].last) void'(rq.pop_front());
        chk("stall", stall, cyc >= st_lo && cyc <= st_hi);
        chk("dmem_req", dmem_req, cyc >= rq_lo && cyc <= rq_hi);
        if (dmem_req && rq.size() > 0) begin
            chk("req_fields", {dmem_we, dmem_be, dmem_addr, dmem_we ? dmem_wdata : 32'h0},
                {rq[0].we, rq[0].be, rq[0].addr, rq[0].we ? rq[0].wdata : 32'h0});
            if (dmem_gnt) void'(rq.pop_front());
        end
        if (q.size() > 0 && cyc > q[0].cyc) begin
            checks++;
            errors++;
            $display("FAIL resp_missing: no pulse, expected kind %b at cycle %0d", q[0].kind, q[0].cyc);
            void'(q.pop_front());
        end
        resp = {load_valid, store_done, misalign, bus_err};
        if (resp != 4'b0) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got pulses %b expected none (cycle %0d)", resp, cyc);
            end else begin
                e = q.pop_front();
                chk("resp_cycle", 128'(cyc), 128'(e.cyc));
                chk("resp_kind", resp, e.kind);
                if (e.chk_load) chk("load_regs", {load_word, load_addr, load_fu3}, {e.word, e.la, e.lf});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sz(input logic rd, input logic [2:0] f3);
        if (rd) return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        return f3 == 3'd0 ? 1 : f3 == 3'd1 ? 2 : 4;
    endfunction

    // Drives one accept cycle and records every expectation it implies. g/r <0 mean never.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input int g, input int r, input logic [31:0] rw,
                         input int spur, output int done, output logic mis);
        int n, s;
        logic tmo;
        exp_t e;
        req_t rr;
        n = cyc;
        s = sz(rd, f3);
        mis = (a % s) != 0;
        mem_read = rd; mem_write = wr; fu3 = f3; alu_addr = a; store_data = sd;
        if (mis) begin
            e.cyc = n + 1; e.kind = 4'b0010; e.chk_load = 1'b0; e.word = '0; e.la = '0; e.lf = '0;
            q.push_back(e);
            st_lo = 0; st_hi = -1; rq_lo = 0; rq_hi = -1;
            done = n + 1;
            return;
        end
        tmo = g < 0 || (rd && r < 0);
        done = tmo ? n + 1 + TMO : rd ? n + 3 + g + r : n + 2 + g;
        e.cyc = done;
        e.kind = tmo ? 4'b0001 : rd ? 4'b1000 : 4'b0100;
        e.chk_load = rd;
        e.word = tmo ? 32'h0 : rw;
        e.la = a[1:0];
        e.lf = f3;
        q.push_back(e);
        rr.last = g < 0 ? n + TMO : n + 1 + g;
        rr.we = ~rd;
        rr.be = rd ? 4'hF : 4'((s == 1 ? 1 : s == 2 ? 3 : 15) << (a % 4));
        rr.addr = a - (a % 4);
        rr.wdata = s == 1 ? {24'h0, sd[7:0]} * 32'h0101_0101 : s == 2 ? {16'h0, sd[15:0]} * 32'h0001_0001 : sd;
        rq.push_back(rr);
        st_lo = n; st_hi = done - 1; rq_lo = n + 1; rq_hi = rr.last;
        gnt_cyc = g < 0 ? -1 : n + 1 + g;
        rv_cyc = (rd && g >= 0 && r >= 0) ? n + 2 + g + r : -1;
        rword = rw;
        spur_cyc = spur < 0 ? -1 : n + spur;
    endtask

    task automatic do_txn(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input int g, input int r, input logic [31:0] rw, input int spur);
        int done;
        logic mis;
        issue(rd, wr, f3, a, sd, g, r, rw, spur, done, mis);
        step();
        mem_read = 1'b0; mem_write = 1'b0;
        if (!mis) while (cyc <= done) step();
    endtask

    function automatic logic [127:0] all_out();
        return {stall, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, load_word,
                load_addr, load_fu3, load_valid, store_done, misalign, bus_err};
    endfunction

    initial begin
        logic [2:0] lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        int done;
        logic mis, rd;
        step();
        chk("reset_outputs", all_out(), 128'h0);
        step();
        rst = 1'b0;
        step();
        do_txn(0, 1, 3'd0, 32'h1003, 32'h0000_00A5, 0, 0, 0, -1);
        do_txn(1, 0, 3'd1, 32'h2002, 0, 3, 1, 32'h8001_7FFF, -1);
        do_txn(1, 0, 3'd2, 32'h3001, 0, 0, 0, 0, -1);
        step();
        do_txn(1, 0, 3'd2, 32'h4000, 0, 1, -1, 32'h1234_5678, TMO + 1);
        spur_cyc = cyc + 1;
        repeat (3) step();
        do_txn(1, 1, 3'd2, 32'h5004, 32'hFFFF_FFFF, 0, 0, 32'hCAFE_F00D, -1);
        do_txn(1, 0, 3'd5, 32'h6006, 0, 2, 1, 32'h0BAD_BEEF, 3);
        do_txn(0, 1, 3'd1, 32'h7002, 32'h0000_BEEF, 1, 0, 0, -1);
        do_txn(0, 1, 3'd7, 32'h7102, 32'h1111_2222, 0, 0, 0, -1);
        do_txn(0, 1, 3'd2, 32'h7200, 32'h3333_4444, -1, 0, 0, -1);
        for (int i = 0; i < 80; i++) begin
            int k;
            logic [2:0] f3;
            k = int'($urandom % 8);
            rd = k < 4;
            f3 = rd ? lf3[$urandom % 5] : 3'($urandom);
            do_txn(rd, k == 0 || !rd, f3, $urandom, $urandom,
                   ($urandom % 10 == 0) ? -1 : int'($urandom % 4),
                   ($urandom % 10 == 0) ? -1 : int'($urandom % 4), $urandom, -1);
            repeat ($urandom % 3) step();
        end
        issue(1, 0, 3'd2, 32'h40, 0, 0, -1, 0, -1, done, mis);
        step();
        mem_read = 1'b0;
        step();
        step();
        rst = 1'b1;
        q.delete(); rq.delete();
        st_lo = 0; st_hi = -1; rq_lo = 0; rq_hi = -1;
        gnt_cyc = -1; rv_cyc = -1; spur_cyc = -1;
        #1;
        chk("reset_async", all_out(), 128'h0);
        step();
        step();
        rst = 1'b0;
        do_txn(0, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, -1);
        repeat (3) step();
        chk("scoreboard_empty", 128'(q.size() + rq.size()), 128'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Memory-stage data-memory access controller. It sits directly upstream of the load alignment/extension unit.
- It accepts load/store requests from the EX/MEM stage, checks alignment, and generates word address, byte enables and replicated store data.
- It runs a req/gnt/rvalid handshake with the data memory and stalls the pipeline while an access is outstanding.
- For loads it delivers the raw 32-bit word together with addr[1:0] and fu3. The downstream unit performs byte/half selection and sign extension.

Parameters:
- TIMEOUT, 16, max cycles spent in REQ+WAIT_R before the access is aborted with bus_err (range 2..255).
- CNT_W, 8, width of the timeout counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  EX/MEM load request
- mem_write  in  1  EX/MEM store request
- fu3  in  3  funct3 of the memory instruction
- alu_addr  in  32  effective byte address
- store_data  in  32  rs2 value
- stall  out  1  freeze upstream pipeline stages
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_be  out  4  byte enables
- dmem_addr  out  32  word address ({alu_addr[31:2],2'b00})
- dmem_wdata  out  32  replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read word
- load_word  out  32  raw word to load unit
- load_addr  out  2  captured alu_addr[1:0]
- load_fu3  out  3  captured fu3
- load_valid  out  1  1-cycle pulse, load_word valid
- store_done  out  1  1-cycle pulse
- misalign  out  1  1-cycle pulse, misaligned access rejected
- bus_err  out  1  1-cycle pulse, timeout

Behaviour:
- Reset: every output is 0, state = IDLE, counter = 0, all capture registers = 0.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE, accept:
  - Accept occurs when mem_read|mem_write is high.
  - If both are high, the access is a load (read wins).
  - Inputs are captured into registers on accept; the inputs are not used after that cycle.
- Misalignment:
  - Misaligned means: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠0.
  - On a misaligned accept there is no request. misalign pulses in the next cycle, the state stays IDLE, and stall=0 throughout.
- Aligned accept:
  - stall=1 combinationally in the accept cycle.
  - The next cycle enters REQ with dmem_req=1 (registered outputs).
- REQ:
  - dmem_req, dmem_we, dmem_be, dmem_addr and dmem_wdata are held stable until dmem_gnt.
  - On gnt: a store goes to DONE; a load goes to WAIT_R. dmem_req drops in the following cycle.
- WAIT_R:
  - On dmem_rvalid, dmem_rdata is captured into load_word and the state goes to DONE.
  - If rvalid arrives in the same cycle as gnt, it is ignored; rvalid is only sampled in WAIT_R.
- DONE:
  - stall=0.
  - Pulses load_valid (load) or store_done (store), then returns to IDLE.
  - A new accept is possible in the cycle after DONE.
- stall: 1 in the aligned-accept cycle, REQ and WAIT_R; 0 otherwise.
- Minimum latency (gnt and rvalid each one cycle after the previous step):
  - load: accept N, load_valid at N+3;
  - store: accept N, store_done at N+2.
- Byte enables and store data:
  - sb: be = 4'b0001<<addr[1:0], wdata = {4{store_data[7:0]}}.
  - sh: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{store_data[15:0]}}.
  - sw: be = 4'b1111, wdata = store_data.
  - Loads: be = 4'b1111, we = 0.
  - An illegal fu3 on a store is handled as sw, with its alignment rule applied.
- Timeout:
  - The counter clears on accept and increments in REQ and WAIT_R.
  - When count reaches TIMEOUT-1 without the awaited event: go to DONE, pulse bus_err instead of load_valid/store_done, load_word = 0, dmem_req drops.
  - A late rvalid arriving in IDLE or DONE is ignored.
- load_word, load_addr and load_fu3 hold their values until the next load capture.
- Reset mid-operation: immediate return to IDLE with outputs 0. Memory responses after reset are ignored unless the FSM is in WAIT_R.

Decomposition:
- Shared package holds:
  - funct3 load/store encodings (LB..LHU, SB/SH/SW);
  - FSM state encoding;
  - the be/wdata lane-replication function.
- One natural sub-module: store_align (combinational fu3/addr/store_data → be/wdata/misalign), reusable by a future cache.

Test Plan:
- sb, alu_addr=0x1003, store_data=0xA5, gnt in the first REQ cycle → dmem_addr=0x1000, be=4'b1000, wdata=0xA5A5A5A5; store_done 2 cycles after accept; stall high for exactly 2 cycles.
- lh, alu_addr=0x2002, gnt after 3 wait cycles, rvalid 2 cycles later with 0x8001_7FFF → load_word=0x80017FFF, load_addr=2, load_fu3=1; load_valid a single pulse; stall low in that cycle.
- lw, alu_addr=0x3001 → no dmem_req; misalign pulses 1 cycle; stall stays 0.
- TIMEOUT=16, load with gnt but never rvalid → bus_err after 16 REQ+WAIT_R cycles, load_word=0, FSM back in IDLE; an rvalid injected afterwards produces no load_valid.
- mem_read=mem_write=1, fu3=2, aligned address → dmem_we=0, load handshake completes with load_valid.
- Assert rst while in WAIT_R → all outputs 0 asynchronously; after release a new sw to 0x10 completes with be=4'b1111.
